// File: rtl/float32_to_q16_16.sv
// -----------------------------------------------------------------------------
// float32_to_q16_16
//
// Converts an IEEE-754 single-precision float into an unsigned Q16.16
// fixed-point word (16 integer bits, 16 fractional bits). The conversion is
// an iterative FSM (IDLE -> UNPACK -> ALIGN -> ROUND -> HOLD). There are
// valid/ready handshakes on both sides, so a stalled consumer back-pressures
// the float producer.
//
// Parameters:
//   ROUND_EN   1 = round-to-nearest-even at the 2^-16 LSB, 0 = truncate
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   in_valid   in_float is valid
//   in_ready   block can accept an input this cycle
//   in_float   IEEE-754 single: [31] sign, [30:23] exponent, [22:0] mantissa
//   out_valid  result fields are valid
//   out_ready  consumer accepts the result
//   out_fixed  unsigned Q16.16 result
//   out_ovf    +Inf or magnitude >= 65536; result saturated to all ones
//   out_neg    negative non-zero input (incl. -Inf); result clamped to 0
//   out_nan    NaN input; result 0
// -----------------------------------------------------------------------------
module float32_to_q16_16 #(
   parameter bit ROUND_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_float,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_fixed,
   output logic        out_ovf,
   output logic        out_neg,
   output logic        out_nan
);

   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ROUND, HOLD} state_t;
   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

   state_t             state, state_nxt;

   logic [31:0]        float_q;
   logic               sign_q;
   cls_t               cls_q;
   logic [23:0]        sig_q;
   logic signed [9:0]  k_q;
   logic [31:0]        value_q;
   logic               guard_q;
   logic               sticky_q;
   logic               big_q;

   logic [9:0]         shift_r;
   logic [47:0]        align_ext;
   logic [31:0]        align_value;
   logic               align_guard;
   logic               align_sticky;
   logic               align_big;

   logic               round_inc;
   logic [32:0]        round_sum;
   logic [31:0]        res_fixed;
   logic               res_ovf;
   logic               res_neg;
   logic               res_nan;

   // ---------------------------------------------------------------- FSM ---
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = UNPACK;
         end
         UNPACK: state_nxt = ALIGN;
         ALIGN:  state_nxt = ROUND;
         ROUND:  state_nxt = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- align ---
   // k is exp - 134: the shift that places the 24-bit significand (binary
   // point after bit 23) onto a Q16.16 grid.
   assign shift_r = 10'(-k_q);

   always_comb begin
      align_ext    = '0;
      align_value  = '0;
      align_guard  = 1'b0;
      align_sticky = 1'b0;
      align_big    = 1'b0;
      if (k_q >= 10'sd9) begin
         align_big = 1'b1;
      end else if (!k_q[9]) begin
         align_value = {8'd0, sig_q} << k_q[3:0];
      end else if (shift_r <= 10'd25) begin
         // Pad 24 zeros below the significand so that the bits shifted out
         // stay visible as guard (top pad bit) and sticky (the rest).
         align_ext    = {sig_q, 24'd0} >> shift_r[4:0];
         align_value  = {8'd0, align_ext[47:24]};
         align_guard  = align_ext[23];
         align_sticky = |align_ext[22:0];
      end else begin
         // Everything lies below the guard position: non-zero but far too
         // small to ever round up.
         align_sticky = 1'b1;
      end
   end

   // -------------------------------------------------------------- round ---
   assign round_inc = ROUND_EN && guard_q && (sticky_q || value_q[0]);
   assign round_sum = {1'b0, value_q} + {32'd0, round_inc};

   // Special classes take priority in this order; at most one flag is set.
   always_comb begin
      res_fixed = '0;
      res_ovf   = 1'b0;
      res_neg   = 1'b0;
      res_nan   = 1'b0;
      if (cls_q == CLS_NAN) begin
         res_nan = 1'b1;
      end else if (sign_q && cls_q != CLS_ZERO) begin
         res_neg = 1'b1;
      end else if (cls_q == CLS_INF || big_q || round_sum[32]) begin
         res_fixed = 32'hFFFF_FFFF;
         res_ovf   = 1'b1;
      end else if (cls_q == CLS_NORM) begin
         res_fixed = round_sum[31:0];
      end
   end

   // ----------------------------------------------------------- datapath ---
   always_ff @(posedge clk) begin
      if (reset) begin
         float_q   <= '0;
         sign_q    <= 1'b0;
         cls_q     <= CLS_ZERO;
         sig_q     <= '0;
         k_q       <= '0;
         value_q   <= '0;
         guard_q   <= 1'b0;
         sticky_q  <= 1'b0;
         big_q     <= 1'b0;
         out_fixed <= '0;
         out_ovf   <= 1'b0;
         out_neg   <= 1'b0;
         out_nan   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) float_q <= in_float;
            end
            UNPACK: begin
               sign_q <= float_q[31];
               sig_q  <= {1'b1, float_q[22:0]};
               k_q    <= $signed({2'b00, float_q[30:23]}) - 10'sd134;
               if (float_q[30:23] == 8'd0)
                  cls_q <= CLS_ZERO;
               else if (float_q[30:23] == 8'hFF)
                  cls_q <= (float_q[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
               else
                  cls_q <= CLS_NORM;
            end
            ALIGN: begin
               value_q  <= align_value;
               guard_q  <= align_guard;
               sticky_q <= align_sticky;
               big_q    <= align_big;
            end
            ROUND: begin
               out_fixed <= res_fixed;
               out_ovf   <= res_ovf;
               out_neg   <= res_neg;
               out_nan   <= res_nan;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float32_to_q16_16.sv
// -----------------------------------------------------------------------------
// tb_float32_to_q16_16
//
// Drives one stimulus stream into two instances of float32_to_q16_16, one
// rounding (ROUND_EN=1) and one truncating (ROUND_EN=0). They run in
// lockstep. A table of vectors carries the expected results for both
// instances. Each expectation goes into a scoreboard queue when its input is
// accepted and is compared when the result appears. Hand-written sequences
// cover back-pressure and reset during a conversion.
// -----------------------------------------------------------------------------
module tb_float32_to_q16_16;

   typedef struct {
      logic [31:0] din;
      logic [31:0] rnd;     // expected out_fixed with ROUND_EN=1
      logic [31:0] trunc;   // expected out_fixed with ROUND_EN=0
      logic [2:0]  flags;   // {ovf, neg, nan}
   } vec_t;

   localparam int N_VEC = 22;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_float;
   logic        out_ready;

   logic        in_ready_r, out_valid_r, ovf_r, neg_r, nan_r;
   logic [31:0] fixed_r;
   logic        in_ready_t, out_valid_t, ovf_t, neg_t, nan_t;
   logic [31:0] fixed_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t sb[$];
   vec_t vecs[N_VEC];

   always #5 clk = ~clk;

   float32_to_q16_16 #(.ROUND_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
      .in_float(in_float), .out_valid(out_valid_r), .out_ready(out_ready),
      .out_fixed(fixed_r), .out_ovf(ovf_r), .out_neg(neg_r), .out_nan(nan_r)
   );

   float32_to_q16_16 #(.ROUND_EN(1'b0)) dut_trunc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
      .in_float(in_float), .out_valid(out_valid_t), .out_ready(out_ready),
      .out_fixed(fixed_t), .out_ovf(ovf_t), .out_neg(neg_t), .out_nan(nan_t)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic send(input vec_t v);
      int waitc = 0;
      in_float = v.din;
      in_valid = 1'b1;
      while (!in_ready_r && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready_r) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Starts at the negedge after acceptance (cycle 1); waits for out_valid.
   task automatic receive();
      int   lat = 1;
      vec_t e;
      while (!out_valid_r && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("latency[%08h]", in_float), 32'(lat), 32'd4);
      if (!out_valid_r) return;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check($sformatf("fixed_rnd[%08h]", e.din), fixed_r, e.rnd);
      check($sformatf("fixed_trunc[%08h]", e.din), fixed_t, e.trunc);
      check($sformatf("flags_rnd[%08h]", e.din),
            {29'd0, ovf_r, neg_r, nan_r}, {29'd0, e.flags});
      check($sformatf("flags_trunc[%08h]", e.din),
            {29'd0, ovf_t, neg_t, nan_t}, {29'd0, e.flags});
      check("valid_trunc", {31'd0, out_valid_t}, 32'd1);
   endtask

   // With out_ready=1 at a negedge in HOLD: handshake, then expect IDLE.
   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_after_hs", {30'd0, out_valid_r, in_ready_r}, 32'b01);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      vecs[0]  = '{32'h3F800000, 32'h00010000, 32'h00010000, 3'b000};
      vecs[1]  = '{32'h4777F600, 32'hF7F60000, 32'hF7F60000, 3'b000};
      vecs[2]  = '{32'h3F000000, 32'h00008000, 32'h00008000, 3'b000};
      vecs[3]  = '{32'h477FFFFF, 32'hFFFFFF00, 32'hFFFFFF00, 3'b000};
      vecs[4]  = '{32'h47800000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100};
      vecs[5]  = '{32'h7F800000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100};
      vecs[6]  = '{32'hC0000000, 32'h00000000, 32'h00000000, 3'b010};
      vecs[7]  = '{32'h7FC00000, 32'h00000000, 32'h00000000, 3'b001};
      vecs[8]  = '{32'h80000000, 32'h00000000, 32'h00000000, 3'b000};
      vecs[9]  = '{32'h37C00000, 32'h00000002, 32'h00000001, 3'b000};
      vecs[10] = '{32'h37000000, 32'h00000000, 32'h00000000, 3'b000};
      vecs[11] = '{32'hFF800000, 32'h00000000, 32'h00000000, 3'b010};
      vecs[12] = '{32'h00400000, 32'h00000000, 32'h00000000, 3'b000};
      vecs[13] = '{32'h80400000, 32'h00000000, 32'h00000000, 3'b000};
      vecs[14] = '{32'h3F7FFFFF, 32'h00010000, 32'h0000FFFF, 3'b000};
      vecs[15] = '{32'h37400000, 32'h00000001, 32'h00000000, 3'b000};
      vecs[16] = '{32'h33000000, 32'h00000000, 32'h00000000, 3'b000};
      vecs[17] = '{32'h3FC00000, 32'h00018000, 32'h00018000, 3'b000};
      vecs[18] = '{32'h3F8000C0, 32'h00010002, 32'h00010001, 3'b000};
      vecs[19] = '{32'h3F800040, 32'h00010000, 32'h00010000, 3'b000};
      vecs[20] = '{32'hFF800001, 32'h00000000, 32'h00000000, 3'b001};
      vecs[21] = '{32'h4F000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_float  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {28'd0, in_ready_r, out_valid_r, in_ready_t, out_valid_t},
            32'b1010);
      check("reset_fixed", fixed_r | fixed_t, 32'd0);
      check("reset_flags", {26'd0, ovf_r, neg_r, nan_r, ovf_t, neg_t, nan_t}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven vectors, out_ready held high.
      for (int i = 0; i < N_VEC; i++) begin
         send(vecs[i]);
         receive();
         release_out();
      end

      // Back-pressure: hold the result for 10 cycles while a new input waits.
      out_ready = 1'b0;
      send('{32'h3F000000, 32'h00008000, 32'h00008000, 3'b000});
      receive();
      in_float = 32'h40000000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp_hold[%0d]", i),
               {30'd0, out_valid_r, in_ready_r}, 32'b10);
         check($sformatf("bp_fixed[%0d]", i), fixed_r, 32'h00008000);
         @(negedge clk);
      end
      release_out();
      send('{32'h40000000, 32'h00020000, 32'h00020000, 3'b000});
      receive();
      release_out();

      // Reset while the conversion is in ALIGN.
      send('{32'h3F800000, 32'h00010000, 32'h00010000, 3'b000});
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      check("rst_mid_ctrl", {30'd0, in_ready_r, out_valid_r}, 32'b10);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid_r || out_valid_t) seen = 1'b1;
      end
      check("rst_mid_no_output", {31'd0, seen}, 32'd0);
      send('{32'h3FC00000, 32'h00018000, 32'h00018000, 3'b000});
      receive();
      release_out();

      check("scoreboard_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/float32_to_q16_16.md
Name: float32_to_q16_16

Overview:
- Converts an IEEE-754 single-precision float into an unsigned Q16.16 fixed-point word: 16 integer bits and 16 fractional bits.
- It is the inverse direction of the amplifier front-end's integer/fraction-to-float path.
- It lets downstream control logic consume float results from the converter chain as plain fixed-point.
- Iterative FSM with valid/ready handshakes on both sides, so it can sit between float producers and integer consumers with back-pressure.

Parameters:
- ROUND_EN, default 1: 1 = round-to-nearest-even at the 2^-16 LSB; 0 = truncate toward zero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_float is valid.
- in_ready  out  1  block can accept an input this cycle.
- in_float  in  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] mantissa.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- out_fixed  out  32  unsigned Q16.16 result.
- out_ovf  out  1  input was +Inf, or its magnitude is >= 65536; result saturated.
- out_neg  out  1  input was negative and non-zero (including -Inf); result clamped to 0.
- out_nan  out  1  input was NaN; result 0.

Behaviour:
- Reset (synchronous, takes effect at the clock edge with reset=1):
  - state=IDLE, in_ready=1, out_valid=0, out_fixed=0, all flags 0.
  - Reset mid-conversion discards the operation; no output is produced.
- FSM: IDLE -> UNPACK -> ALIGN -> ROUND -> HOLD -> IDLE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge: capture in_float, go to UNPACK, in_ready=0 next cycle.
- UNPACK:
  - Classify the input: zero/denormal (exp=0), Inf (exp=255, mant=0), NaN (exp=255, mant!=0), normal.
  - Form sig = {1,mant} (24 bits). Compute k = exp - 134 (signed).
- ALIGN:
  - k >= 9 (exp >= 143): overflow.
  - 0 <= k <= 8: value = sig << k. Exact, so guard=0 and sticky=0.
  - k < 0, r = -k:
    - r <= 25: value = sig >> r; guard = bit r-1 of sig; sticky = OR of sig bits below r-1.
    - r >= 26: value=0, guard=0, sticky=1.
- ROUND:
  - ROUND_EN=1: increment when guard && (sticky || value[0]).
  - ROUND_EN=0: no increment.
  - A carry out of bit 31 saturates to 0xFFFFFFFF and sets ovf.
  - Special cases:
    - NaN -> 0 with nan=1.
    - sign=1 and not zero/denormal -> 0 with neg=1.
    - +Inf or overflow -> 0xFFFFFFFF with ovf=1.
    - +/-0 and denormals -> 0, no flags.
  - At most one flag is set per result.
- HOLD:
  - out_valid=1; out_fixed and flags stable.
  - out_ready=1 at an edge: out_valid=0 and IDLE (in_ready=1) next cycle.
  - out_ready is ignored in every other state.
- Latency:
  - Input accepted at edge N; out_valid=1 in the cycle after edge N+3.
  - Minimum spacing between accepted inputs is 5 cycles when out_ready is held at 1.
- in_valid while in_ready=0 is ignored; the producer must hold its data until accepted.
- Outputs are registered; no combinational path from in_* to out_*.

Test Plan:
- After reset, in_float=0x3F800000 (1.0), out_ready=1 -> out_fixed=0x00010000, no flags, out_valid exactly 4 cycles after acceptance.
- 0x4777F600 (63478.0) -> 0xF7F60000. 0x3F000000 (0.5) -> 0x00008000. 0x477FFFFF -> 0xFFFFFF00, ovf=0.
- 0x47800000 (65536.0) and 0x7F800000 (+Inf) -> 0xFFFFFFFF, ovf=1. 0xC0000000 (-2.0) -> 0, neg=1. 0x7FC00000 -> 0, nan=1. 0x80000000 -> 0, no flags.
- Rounding, ROUND_EN=1: 0x37C00000 (1.5 LSB) -> 0x00000002; 0x37000000 (0.5 LSB tie) -> 0x00000000. With ROUND_EN=0, 0x37C00000 -> 0x00000001.
- Back-pressure: hold out_ready=0 for 10 cycles -> out_valid and out_fixed stable, in_ready=0, a new in_valid is ignored; release -> IDLE next cycle, then the new input is accepted.
- Assert reset during ALIGN -> no out_valid is ever produced, in_ready=1 the cycle after reset, and the next conversion is correct.
